// File: rtl/struct_port_pkg.sv
// Shared types for the struct-typed valid/ready byte link.
package struct_port_pkg;

  localparam int SEQ_W = 4;

  typedef logic [7:0] byte_t;

  // One beat on the link: payload, position in frame, end-of-frame marker.
  typedef struct packed {
    byte_t            data;
    logic [SEQ_W-1:0] seq;
    logic             last;
  } pkt_t;

  // One queued producer byte waiting in the FIFO.
  typedef struct packed {
    byte_t data;
    logic  last;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_FLUSH = 2'd2
  } tx_state_t;

endpackage

// File: rtl/struct_port_if.sv
// Valid/ready link carrying pkt_t beats; TX drives valid/pkt, RX drives ready.
interface I_hs;
  import struct_port_pkg::*;

  logic valid;
  logic ready;
  pkt_t pkt;

  modport TX (output valid, output pkt, input ready);
  modport RX (input valid, input pkt, output ready);
endinterface

// File: rtl/struct_port_fifo.sv
// Byte+last FIFO with wrap-bit pointers and a synchronous flush.
module struct_port_fifo
  import struct_port_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  entry_t                   i_wdata,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output entry_t                   o_rdata,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  entry_t      mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Full when the pointers sit on the same slot but on different laps.
  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign o_count = wr_ptr - rd_ptr;
  assign o_rdata = mem[rd_ptr[AW-1:0]];

  assign do_push = i_push && !o_full && !i_flush;
  assign do_pop  = i_pop && !o_empty && !i_flush;

  // Pointer update; flush discards everything queued in one edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset since the pointers gate reads.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/struct_port_tx.sv
// Writer end of the I_hs link: buffers producer bytes and presents them as
// sequence-numbered pkt_t beats under valid/ready.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | output register empty; load it as soon as the FIFO has data
//   ST_SEND  | beat presented; reload from FIFO on transfer or go idle
//   ST_FLUSH | FIFO discarded; wait for any held beat to drain, clear seq
module struct_port_tx
  import struct_port_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [7:0]                   i_data,
  input  logic                         i_last,
  input  logic                         i_flush,
  I_hs.TX                              p_tx,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic [7:0]                   o_frames
);

  tx_state_t        state_q;
  tx_state_t        state_d;
  logic             rdy_en_q;
  entry_t           head;
  entry_t           wdata;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             load;
  logic             seq_clr;
  logic             transfer;
  logic             valid_q;
  pkt_t             pkt_q;
  logic [SEQ_W-1:0] seq_q;
  logic [SEQ_W-1:0] seq_d;

  // Ready is a function of registered occupancy, so a pop cannot free a slot
  // for a push in the same cycle.
  assign o_ready  = rdy_en_q && !fifo_full && !i_flush;
  assign push     = i_valid && o_ready;
  assign transfer = valid_q && p_tx.ready;
  assign wdata    = '{data: i_data, last: i_last};

  assign p_tx.valid = valid_q;
  assign p_tx.pkt   = pkt_q;

  struct_port_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_wdata (wdata),
    .i_pop   (load),
    .i_flush (i_flush),
    .o_rdata (head),
    .o_empty (fifo_empty),
    .o_full  (fifo_full),
    .o_count (o_count)
  );

  // Hold o_ready low until the first edge after reset release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rdy_en_q <= 1'b0;
    else          rdy_en_q <= 1'b1;
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; flush overrides every state.
  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_IDLE:  if (!fifo_empty) state_d = ST_SEND;
        ST_SEND:  if (transfer && fifo_empty) state_d = ST_IDLE;
        ST_FLUSH: if (!valid_q || transfer) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Output decode: when to pull the FIFO head and when a flush has drained.
  always_comb begin
    load    = 1'b0;
    seq_clr = 1'b0;
    case (state_q)
      ST_IDLE:  load    = !fifo_empty && !i_flush;
      ST_SEND:  load    = !fifo_empty && !i_flush && transfer;
      ST_FLUSH: seq_clr = !i_flush && (!valid_q || transfer);
      default:  ;
    endcase
  end

  // Sequence value after this edge; a reloaded beat takes it directly so
  // back-to-back beats number consecutively.
  always_comb begin
    seq_d = seq_q;
    if (seq_clr)       seq_d = '0;
    else if (transfer) seq_d = pkt_q.last ? '0 : seq_q + SEQ_W'(1);
  end

  // Output register: valid and pkt hold until the beat transfers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      pkt_q   <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      pkt_q   <= '{data: head.data, seq: seq_d, last: head.last};
    end else if (transfer) begin
      valid_q <= 1'b0;
    end
  end

  // Running sequence counter and completed-frame count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      seq_q    <= '0;
      o_frames <= '0;
    end else begin
      seq_q <= seq_d;
      if (transfer && pkt_q.last) o_frames <= o_frames + 8'd1;
    end
  end

endmodule
